store_merge_unit: RTL



---
 rtl/store_merge_unit.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/store_merge_unit.sv
// -----------------------------------------------------------------------------
// store_merge_unit
//
// Store-data path between the register file and a word-wide data memory that
// has no byte enables. Full-word stores are written straight through; byte and
// halfword stores read the addressed word, merge the new lanes in, and write
// the merged word back.
//
// Parameters:
//   DATA_W     memory word width (power-of-two multiple of BYTE_W, >= 2 lanes)
//   BYTE_W     lane width
//   ADDR_W     byte-address width
//   MEM_RD_LAT cycles from mem_re to valid mem_rdata (1..4)
//
// Ports:
//   clk, rst   clock; synchronous active-high reset
//   start      request strobe, sampled only when idle
//   addr       byte address of the store
//   size       log2 of store size in bytes (clamped to a full word)
//   wdata      right-justified store data
//   mem_addr   word address (latched addr >> LB)
//   mem_re     memory read strobe
//   mem_rdata  memory read data
//   mem_we     memory write strobe
//   mem_wdata  merged write word
//   busy       high whenever not idle
//   done       one-cycle pulse with mem_we
//   err        one-cycle misalignment pulse (trap build only, else 0)
//
// Build option: define STORE_MISALIGN_TRAP_EN to trap misaligned stores
// (IDLE -> ERR -> IDLE with an err pulse) instead of force-aligning them.
// -----------------------------------------------------------------------------
module store_merge_unit #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned BYTE_W     = 8,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MEM_RD_LAT = 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [ADDR_W-1:0]                       addr,
    input  logic [1:0]                              size,
    input  logic [DATA_W-1:0]                       wdata,
    output logic [ADDR_W-$clog2(DATA_W/BYTE_W)-1:0] mem_addr,
    output logic                                    mem_re,
    input  logic [DATA_W-1:0]                       mem_rdata,
    output logic                                    mem_we,
    output logic [DATA_W-1:0]                       mem_wdata,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    err
);

    localparam int unsigned NLANES = DATA_W / BYTE_W;
    localparam int unsigned LB     = $clog2(NLANES);
    localparam int unsigned NBW    = LB + 1;
    localparam int unsigned CW     = 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_RD_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_ERR
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-LB-1:0]   addr_q;
    logic [LB-1:0]          off_q;
    logic [NBW-1:0]         nb_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [CW-1:0]          cnt_q;
    logic [DATA_W-1:0]      merged;

    int unsigned nb_req, nb, lo, off;
    int unsigned off_i, nb_i;
`ifdef STORE_MISALIGN_TRAP_EN
    logic misalign;
`endif

    // Decode the incoming request: clamp the byte count to a word and
    // force-align the lane offset to the store size.
    always_comb begin
        nb_req = 32'd1 << size;
        nb     = (nb_req > NLANES) ? NLANES : nb_req;
        lo     = 32'(addr[LB-1:0]);
        off    = lo & ~(nb - 32'd1);
`ifdef STORE_MISALIGN_TRAP_EN
        misalign = (lo & (nb - 32'd1)) != 32'd0;
`endif
    end

    // Lanes inside [off, off+nb) take the store data, the rest keep the
    // word read back from memory.
    always_comb begin
        off_i  = 32'(off_q);
        nb_i   = 32'(nb_q);
        merged = mem_rdata;
        for (int unsigned k = 0; k < NLANES; k++) begin
            if (k >= off_i && k < off_i + nb_i) begin
                merged[k*BYTE_W +: BYTE_W] = wdata_q[(k - off_i)*BYTE_W +: BYTE_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef STORE_MISALIGN_TRAP_EN
                    if (misalign)          state_d = S_ERR;
                    else
`endif
                    if (nb == NLANES)      state_d = S_WRITE;
                    else                   state_d = S_READ;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  if (cnt_q == CNT_LAST) state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_re = (state_q == S_READ);
        mem_we = (state_q == S_WRITE);
        done   = (state_q == S_WRITE);
        busy   = (state_q != S_IDLE);
`ifdef STORE_MISALIGN_TRAP_EN
        err    = (state_q == S_ERR);
`else
        err    = 1'b0;
`endif
    end

    assign mem_addr = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            off_q     <= '0;
            nb_q      <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q    <= addr[ADDR_W-1:LB];
                        off_q     <= LB'(off);
                        nb_q      <= NBW'(nb);
                        wdata_q   <= wdata;
                        cnt_q     <= '0;
                        // Full-word stores write this directly; partial
                        // stores overwrite it at the capture cycle.
                        mem_wdata <= wdata;
                    end
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) mem_wdata <= merged;
                end
                default: ;
            endcase
        end
    end

endmodule
